// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze sequencer for a 5-stage pipeline: arbitrates shared-memory
// waits, taken branches, halt draining and load-use hazards, and counts stalls.
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic             ex_mem_read_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    input  logic             halt_req_i,
    output logic             pc_write_en_o,
    output logic             if_id_write_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_stall_o,
    output logic             pipe_freeze_o,
    output logic             halted_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [1:0]       state_dbg_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_e;

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int WAIT_W  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

    state_e             state_q, state_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic lu_s;
    logic mem_block_s;
    logic run_pc_we_s, run_ifid_we_s, run_flush_s, run_stall_s, run_halt_s;
    logic pc_we_s, ifid_we_s, flush_s, stall_s, freeze_s, halted_s;

    assign lu_s = ex_mem_read_i && (ex_rd_addr_i != 5'd0) &&
                  ((id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                   (id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i)));

    assign mem_block_s = mem_req_i && !mem_ready_i;

    // Branch / halt / load-use priority once memory is not blocking the pipe.
    always_comb begin
        run_pc_we_s   = 1'b1;
        run_ifid_we_s = 1'b1;
        run_flush_s   = 1'b0;
        run_stall_s   = 1'b0;
        run_halt_s    = 1'b0;
        if (ex_branch_taken_i) begin
            // The dependent instruction is squashed, so the branch beats load-use.
            run_flush_s = 1'b1;
            run_stall_s = 1'b1;
        end else if (halt_req_i && !lu_s) begin
            run_pc_we_s = 1'b0;
            run_flush_s = 1'b1;
            run_halt_s  = 1'b1;
        end else if (lu_s) begin
            run_pc_we_s   = 1'b0;
            run_ifid_we_s = 1'b0;
            run_stall_s   = 1'b1;
        end else begin
            run_pc_we_s   = 1'b1;
            run_ifid_we_s = 1'b1;
        end
    end

    // Sequencer next state, counters and control outputs.
    always_comb begin
        pc_we_s     = run_pc_we_s;
        ifid_we_s   = run_ifid_we_s;
        flush_s     = run_flush_s;
        stall_s     = run_stall_s;
        freeze_s    = 1'b0;
        halted_s    = 1'b0;
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;

        case (state_q)
            ST_RUN: begin
                if (mem_block_s) begin
                    pc_we_s   = 1'b0;
                    ifid_we_s = 1'b0;
                    flush_s   = 1'b0;
                    stall_s   = 1'b0;
                    freeze_s  = 1'b1;
                    state_d   = ST_MEM_WAIT;
                end else begin
                    state_d     = run_halt_s ? ST_DRAIN : ST_RUN;
                    drain_cnt_d = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ready_i) begin
                    pc_we_s    = 1'b0;
                    ifid_we_s  = 1'b0;
                    flush_s    = 1'b0;
                    stall_s    = 1'b0;
                    freeze_s   = 1'b1;
                    wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
                    timeout_d  = timeout_q | (wait_cnt_d == WAIT_MAX);
                end else begin
                    wait_cnt_d  = '0;
                    state_d     = run_halt_s ? ST_DRAIN : ST_RUN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if (mem_block_s) begin
                    pc_we_s   = 1'b0;
                    ifid_we_s = 1'b0;
                    flush_s   = 1'b0;
                    stall_s   = 1'b0;
                    freeze_s  = 1'b1;
                end else begin
                    pc_we_s   = ex_branch_taken_i;
                    ifid_we_s = 1'b1;
                    flush_s   = 1'b1;
                    stall_s   = ex_branch_taken_i;
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d     = ST_HALTED;
                        drain_cnt_d = '0;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                pc_we_s   = 1'b0;
                ifid_we_s = 1'b0;
                flush_s   = 1'b1;
                stall_s   = 1'b1;
                halted_s  = 1'b1;
                state_d   = halt_req_i ? ST_HALTED : ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if ((state_q != ST_HALTED) && !pc_we_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, counter and sticky-flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pc_write_en_o    = rst ? 1'b0 : pc_we_s;
    assign if_id_write_en_o = rst ? 1'b0 : ifid_we_s;
    assign if_id_flush_o    = rst ? 1'b0 : flush_s;
    assign id_ex_stall_o    = rst ? 1'b1 : stall_s;
    assign pipe_freeze_o    = rst ? 1'b0 : freeze_s;
    assign halted_o         = rst ? 1'b0 : halted_s;
    assign mem_timeout_o    = timeout_q;
    assign stall_cycles_o   = stall_cnt_q;
    assign state_dbg_o      = state_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush/freeze sequencer for one core's 5-stage pipeline.
- Drives the PC enable, the IF/ID write and flush controls, the ID/EX bubble input (pipeline_stall), and a global freeze for the ID/EX, EX/MEM and MEM/WB holds.
- Arbitrates four conditions: shared-memory wait, taken branch, halt/drain request, load-use hazard.
- Keeps a FSM for memory-wait and halt-drain sequencing, plus stall statistics.

Parameters:
DRAIN_CYCLES, 4, unfrozen cycles spent draining before entering HALTED (min 1)
MEM_TIMEOUT, 255, consecutive MEM_WAIT cycles before the sticky timeout flag sets
CNT_W, 32, width of the stall statistics counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
id_rs1_addr  in  5  rs1 of the instruction in ID
id_rs2_addr  in  5  rs2 of the instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_mem_read  in  1  instruction in EX is a load
ex_rd_addr  in  5  rd of the instruction in EX
ex_branch_taken  in  1  EX resolved a taken branch or jump
mem_req  in  1  MEM stage has an outstanding shared-memory access
mem_ready  in  1  shared memory completes the access this cycle
halt_req  in  1  core halt request (level)
pc_write_en  out  1  PC register update enable
if_id_write_en  out  1  IF/ID load enable
if_id_flush  out  1  load a NOP into IF/ID
id_ex_stall  out  1  insert a bubble into ID/EX
pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
halted  out  1  core is in the HALTED state
mem_timeout  out  1  sticky: memory wait exceeded MEM_TIMEOUT
stall_cycles  out  CNT_W  saturating count of stalled cycles
state_dbg  out  2  current state: 0 RUN, 1 MEM_WAIT, 2 DRAIN, 3 HALTED

Behaviour:
- Control outputs are combinational from the registered state and the current inputs. State, counters and flags update on the rising edge of clk.
- While rst=1: state=RUN, counters=0, mem_timeout=0. Forced outputs: pc_write_en=0, if_id_write_en=0, if_id_flush=0, id_ex_stall=1, pipe_freeze=0, halted=0.
- Default outputs (no condition active): pc_write_en=1, if_id_write_en=1, all other control outputs 0.
- Load-use hazard (lu) is true when all hold: ex_mem_read=1, ex_rd_addr≠0, and ((id_uses_rs1 and rs1==rd) or (id_uses_rs2 and rs2==rd)).
- RUN, evaluated in priority order:
  1. mem_req and !mem_ready → freeze: pipe_freeze=1, pc_write_en=0, if_id_write_en=0, no flush or stall. Next state MEM_WAIT.
  2. ex_branch_taken → pc_write_en=1, if_id_flush=1, id_ex_stall=1. Stay in RUN. A branch beats lu because the dependent instruction is squashed.
  3. halt_req and !lu → pc_write_en=0, if_id_flush=1. Next state DRAIN with the drain counter cleared.
  4. lu → pc_write_en=0, if_id_write_en=0, id_ex_stall=1, for exactly one cycle (the hazard clears naturally once the bubble reaches EX).
- MEM_WAIT:
  - mem_ready=0 → freeze outputs. Wait counter increments; on reaching MEM_TIMEOUT set mem_timeout (stays set until rst). State remains MEM_WAIT.
  - mem_ready=1 → release. This cycle evaluates exactly as RUN rules 2–4 (rule 1 is not re-taken). Next state is RUN, or DRAIN if rule 3 fires. The wait counter is cleared.
- DRAIN:
  - mem_req and !mem_ready → freeze; the drain counter is paused; state remains DRAIN.
  - Otherwise: if_id_flush=1, id_ex_stall=ex_branch_taken, pc_write_en=ex_branch_taken. The drain counter increments.
  - When the counter reaches DRAIN_CYCLES-1 → next state HALTED.
  - halt_req dropping during DRAIN does not abort the drain.
- HALTED: pc_write_en=0, if_id_write_en=0, if_id_flush=1, id_ex_stall=1, halted=1. When halt_req=0 → next state RUN. Execution resumes at the held PC.
- stall_cycles: +1 on every cycle outside rst and HALTED where pc_write_en=0. Saturates at all-ones.
- Asynchronous rst mid-operation (any state) returns immediately to the reset values above.

Test Plan:
- Load-use: EX holds lw x5, ID holds add x6,x5,x1 → exactly one cycle with pc_write_en=0, if_id_write_en=0, id_ex_stall=1; stall_cycles=1. Same case with ex_rd_addr=0 → no stall.
- Memory wait: mem_req=1 with mem_ready low for 3 cycles → pipe_freeze=1 for 3 cycles and state_dbg=1. On mem_ready=1 → state_dbg=0 next cycle, stall_cycles=3.
- Branch plus load-use in the same cycle → if_id_flush=1, id_ex_stall=1, pc_write_en=1 (branch wins). The same branch during a mem wait is taken only in the release cycle.
- Halt: halt_req pulses high in RUN → 4 DRAIN cycles with if_id_flush=1, then halted=1. Drop halt_req → RUN, pc_write_en=1. A mem wait of 2 cycles during DRAIN extends the drain to 6 cycles.
- Timeout: MEM_TIMEOUT=8, mem_ready held low → mem_timeout=1 after 8 MEM_WAIT cycles, still 1 after mem_ready. Assert rst mid-wait → state_dbg=0, mem_timeout=0, stall_cycles=0 immediately.
